// File: rtl/alu_share_pkg.sv
// Shared types and constants for the ALU-sharing arbiter.
package alu_share_pkg;
    localparam int DATA_W    = 32;
    localparam int ALU_SEL_W = 3;

    localparam logic [ALU_SEL_W-1:0] ALU_AND = 3'b000;
    localparam logic [ALU_SEL_W-1:0] ALU_OR  = 3'b001;
    localparam logic [ALU_SEL_W-1:0] ALU_ADD = 3'b010;
    localparam logic [ALU_SEL_W-1:0] ALU_XOR = 3'b011;
    localparam logic [ALU_SEL_W-1:0] ALU_NOR = 3'b100;
    localparam logic [ALU_SEL_W-1:0] ALU_SRL = 3'b101;
    localparam logic [ALU_SEL_W-1:0] ALU_SUB = 3'b110;
    localparam logic [ALU_SEL_W-1:0] ALU_SLT = 3'b111;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU shared by all requesters.
module alu
    import alu_share_pkg::*;
(
    input  logic [DATA_W-1:0]    A,
    input  logic [DATA_W-1:0]    B,
    input  logic [ALU_SEL_W-1:0] ALU_Sel,
    output logic [DATA_W-1:0]    R,
    output logic                 Zero_Flag
);
    always_comb begin
        R = '0;
        case (ALU_Sel)
            ALU_AND: R = A & B;
            ALU_OR:  R = A | B;
            ALU_ADD: R = A + B;
            ALU_XOR: R = A ^ B;
            ALU_NOR: R = ~(A | B);
            ALU_SRL: R = A >> B[4:0];
            ALU_SUB: R = A - B;
            ALU_SLT: R = DATA_W'($signed(A) < $signed(B));
            default: R = '0;
        endcase
    end

    assign Zero_Flag = (R == '0);
endmodule

// File: rtl/alu_share_arb_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick #(
    parameter  int NREQ = 4,
    localparam int ID_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] ptr,
    output logic            any,
    output logic [ID_W-1:0] gnt_idx
);
    int idx;

    // Scan from the farthest offset down so the nearest set request wins last.
    always_comb begin
        any     = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NREQ;
            if (req[idx]) begin
                any     = 1'b1;
                gnt_idx = ID_W'(idx);
            end
        end
    end
endmodule

// File: rtl/alu_share_arb.sv
// Round-robin arbiter sequencing NREQ requesters through one shared ALU.
module alu_share_arb
    import alu_share_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int ID_W = $clog2(NREQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*DATA_W-1:0]    req_a,
    input  logic [NREQ*DATA_W-1:0]    req_b,
    input  logic [NREQ*ALU_SEL_W-1:0] req_sel,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_r,
    output logic                      rsp_zero,
    output logic                      busy
);
    state_t               state_reg;
    logic [ID_W-1:0]      rr_ptr_reg;
    logic [DATA_W-1:0]    a_reg;
    logic [DATA_W-1:0]    b_reg;
    logic [ALU_SEL_W-1:0] sel_reg;
    logic [ID_W-1:0]      id_reg;

    logic [DATA_W-1:0]    a_arr   [NREQ];
    logic [DATA_W-1:0]    b_arr   [NREQ];
    logic [ALU_SEL_W-1:0] sel_arr [NREQ];

    logic                 pick_any;
    logic [ID_W-1:0]      pick_idx;
    logic [ID_W-1:0]      ptr_next;
    logic                 grant_opp;
    logic                 grant;
    logic [DATA_W-1:0]    alu_r;
    logic                 alu_zero;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
            assign a_arr[gi]     = req_a[DATA_W*gi +: DATA_W];
            assign b_arr[gi]     = req_b[DATA_W*gi +: DATA_W];
            assign sel_arr[gi]   = req_sel[ALU_SEL_W*gi +: ALU_SEL_W];
            assign req_ready[gi] = grant && (pick_idx == ID_W'(gi));
        end
    endgenerate

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req     (req_valid),
        .ptr     (rr_ptr_reg),
        .any     (pick_any),
        .gnt_idx (pick_idx)
    );

    alu u_alu (
        .A         (a_reg),
        .B         (b_reg),
        .ALU_Sel   (sel_reg),
        .R         (alu_r),
        .Zero_Flag (alu_zero)
    );

    // rst_n gates the grant so no requester sees an accept while held in reset.
    assign grant_opp = (state_reg == IDLE) || ((state_reg == RESP) && rsp_ready);
    assign grant     = grant_opp && pick_any && rst_n;
    assign ptr_next  = (pick_idx == ID_W'(NREQ - 1)) ? '0 : pick_idx + 1'b1;

    assign rsp_valid = (state_reg == RESP);
    assign busy      = (state_reg != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            rr_ptr_reg <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            sel_reg    <= '0;
            id_reg     <= '0;
            rsp_r      <= '0;
            rsp_zero   <= 1'b0;
            rsp_id     <= '0;
        end else begin
            if (grant) begin
                a_reg      <= a_arr[pick_idx];
                b_reg      <= b_arr[pick_idx];
                sel_reg    <= sel_arr[pick_idx];
                id_reg     <= pick_idx;
                rr_ptr_reg <= ptr_next;
            end
            case (state_reg)
                IDLE: if (grant) state_reg <= EXEC;
                EXEC: begin
                    rsp_r     <= alu_r;
                    rsp_zero  <= alu_zero;
                    rsp_id    <= id_reg;
                    state_reg <= RESP;
                end
                RESP: if (rsp_ready) state_reg <= grant ? EXEC : IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb with hand-computed expectations.
module tb_alu_share_arb;
    import alu_share_pkg::*;

    localparam int NREQ = 4;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic [NREQ-1:0]           req_valid;
    logic [NREQ-1:0]           req_ready;
    logic [NREQ*32-1:0]        req_a;
    logic [NREQ*32-1:0]        req_b;
    logic [NREQ*3-1:0]         req_sel;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [1:0]                rsp_id;
    logic [31:0]               rsp_r;
    logic                      rsp_zero;
    logic                      busy;

    int total = 0;
    int bad   = 0;

    alu_share_arb #(.NREQ(NREQ)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_sel   (req_sel),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_r     (rsp_r),
        .rsp_zero  (rsp_zero),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
    endtask

    task automatic chk_rsp(input string tag, input logic [1:0] id, input logic [31:0] r,
                           input logic z);
        chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, "_id"},    32'(rsp_id),    32'(id));
        chk({tag, "_r"},     rsp_r,          r);
        chk({tag, "_zero"},  32'(rsp_zero),  32'(z));
        $display("rsp %s: id=%0d r=%0d zero=%0b", tag, rsp_id, rsp_r, rsp_zero);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] fair_seq;
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_sel   = {NREQ{ALU_ADD}};
        rsp_ready = 1'b1;
        repeat (2) tick();
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_rsp_r",     rsp_r,          32'd0);
        chk("rst_rsp_zero",  32'(rsp_zero),  32'd0);
        chk("rst_rsp_id",    32'(rsp_id),    32'd0);

        // Contention: all four valid while reset is still asserted.
        for (int i = 0; i < NREQ; i++) set_op(i, 32'(100 + i), 32'(i));
        req_valid = 4'hF;
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("cont_ready0", 32'(req_ready), 32'h1);
        for (int i = 0; i < NREQ; i++) begin
            tick();
            req_valid[i] = 1'b0;
            #1;
            chk("cont_exec_ready", 32'(req_ready), 32'd0);
            chk("cont_exec_valid", 32'(rsp_valid), 32'd0);
            chk("cont_exec_busy",  32'(busy),      32'd1);
            tick();
            chk_rsp("cont", 2'(i), 32'(100 + 2 * i), 1'b0);
            chk("cont_next_ready", 32'(req_ready), (i < NREQ - 1) ? (32'd1 << (i + 1)) : 32'd0);
        end
        tick();
        chk("cont_idle_busy", 32'(busy), 32'd0);

        // Fairness: req0 and req2 continuously valid, rr_ptr starts at 0.
        set_op(0, 32'd5, 32'd5);
        set_op(2, 32'd7, 32'd1);
        req_valid = 4'b0101;
        #1;
        chk("fair_ready_first", 32'(req_ready), 32'h1);
        fair_seq = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (k == 3) req_valid = '0;
            #1;
            chk("fair_exec_ready", 32'(req_ready), 32'd0);
            tick();
            if (fair_seq[k]) chk_rsp("fair", 2'd2, 32'd8, 1'b0);
            else             chk_rsp("fair", 2'd0, 32'd10, 1'b0);
            chk("fair_next_ready", 32'(req_ready),
                (k == 3) ? 32'd0 : (fair_seq[k] ? 32'h1 : 32'h4));
        end
        tick();

        // Single request from req0 (rr_ptr is 3 here, search wraps to 0).
        set_op(0, 32'd12, 32'd7);
        req_valid = 4'b0001;
        #1;
        chk("single_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        #1;
        chk("single_ready_drop", 32'(req_ready), 32'd0);
        tick();
        chk_rsp("single", 2'd0, 32'd19, 1'b0);
        tick();

        // Zero flag from req1.
        set_op(1, 32'd0, 32'd0);
        req_valid = 4'b0010;
        #1;
        chk("zero_ready", 32'(req_ready), 32'h2);
        tick();
        req_valid = '0;
        tick();
        chk_rsp("zero", 2'd1, 32'd0, 1'b1);
        tick();

        // Backpressure: req2 response held while req3 waits.
        set_op(2, 32'd20, 32'd22);
        set_op(3, 32'd3, 32'd4);
        req_valid = 4'b0100;
        #1;
        chk("bp_ready2", 32'(req_ready), 32'h4);
        tick();
        req_valid = 4'b1000;
        rsp_ready = 1'b0;
        #1;
        chk("bp_exec_ready", 32'(req_ready), 32'd0);
        tick();
        for (int c = 0; c < 5; c++) begin
            chk_rsp("bp_hold", 2'd2, 32'd42, 1'b0);
            chk("bp_hold_ready", 32'(req_ready), 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(req_ready), 32'h8);
        tick();
        req_valid = '0;
        tick();
        chk_rsp("bp_req3", 2'd3, 32'd7, 1'b0);
        tick();

        // Reset during EXEC: req1 granted, then reset pulsed.
        set_op(1, 32'd9, 32'd9);
        req_valid = 4'b0010;
        #1;
        chk("rex_ready", 32'(req_ready), 32'h2);
        tick();
        req_valid = '0;
        #1;
        chk("rex_in_exec", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rex_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rex_busy",      32'(busy),      32'd0);
        chk("rex_rsp_r",     rsp_r,          32'd0);
        chk("rex_rsp_id",    32'(rsp_id),    32'd0);
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("rex_no_rsp", 32'(rsp_valid), 32'd0);
            tick();
        end
        set_op(1, 32'd2, 32'd3);
        set_op(3, 32'd50, 32'd50);
        req_valid = 4'b1010;
        #1;
        chk("rex_ptr_zero", 32'(req_ready), 32'h2);
        tick();
        req_valid = 4'b1000;
        tick();
        chk_rsp("rex_after", 2'd1, 32'd5, 1'b0);
        req_valid = '0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
